// File: rtl/div_seq.sv
// Multi-cycle restoring divider (DIV/DIVU): one quotient bit per clock plus a sign-fix cycle.
// Optional DIV_DBZ_DETECT_EN: zero divisor short-circuits to FIX and raises o_dbz.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_signed_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
`ifdef DIV_DBZ_DETECT_EN
  ,output logic            o_dbz
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_q_neg, r_r_neg;
  logic [WIDTH-1:0] r_quotient, r_remainder;
  logic             r_busy, r_done;
`ifdef DIV_DBZ_DETECT_EN
  logic             r_dbz_pend, r_dbz;
`endif

  logic             w_a_neg, w_b_neg, w_dbz;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_rem_sh, w_trial;

  assign w_a_neg  = i_signed_op & i_dividend[WIDTH-1];
  assign w_b_neg  = i_signed_op & i_divisor[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -i_dividend : i_dividend;
  assign w_b_mag  = w_b_neg ? -i_divisor  : i_divisor;
  // Shifted remainder can reach 2*divisor-1, so the trial subtract needs one extra bit.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_dvs};

`ifdef DIV_DBZ_DETECT_EN
  assign w_dbz = (i_divisor == '0);
`else
  assign w_dbz = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef DIV_DBZ_DETECT_EN
      r_dbz_pend  <= 1'b0;
      r_dbz       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          r_busy <= 1'b1;
          r_cnt  <= '0;
          r_dvs  <= w_b_mag;
`ifdef DIV_DBZ_DETECT_EN
          r_dbz_pend <= w_dbz;
`endif
          // Zero divisor: preload the FIX inputs so it emits all-ones / raw dividend.
          if (w_dbz) begin
            r_quo   <= '1;
            r_rem   <= i_dividend;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_state <= FIX;
          end else begin
            r_quo   <= w_a_mag;
            r_rem   <= '0;
            r_q_neg <= w_a_neg ^ w_b_neg;
            r_r_neg <= w_a_neg;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
          r_rem <= w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
          if (r_cnt == CW'(WIDTH-1)) r_state <= FIX;
          else                       r_cnt   <= r_cnt + CW'(1);
        end
        FIX: begin
          r_quotient  <= r_q_neg ? -r_quo : r_quo;
          r_remainder <= r_r_neg ? -r_rem : r_rem;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
`ifdef DIV_DBZ_DETECT_EN
          r_dbz       <= r_dbz_pend;
`endif
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;
`ifdef DIV_DBZ_DETECT_EN
  assign o_dbz       = r_dbz;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq (WIDTH=32): latency, signed/unsigned results, ignored and back-to-back starts, reset abort, divide by zero.
module tb_div_seq;
  logic        clk, rst, start, signed_op;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] quotient, remainder;
`ifdef DIV_DBZ_DETECT_EN
  logic        dbz;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  div_seq #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_signed_op(signed_op),
    .i_dividend(dividend), .i_divisor(divisor),
    .o_busy(busy), .o_done(done), .o_quotient(quotient), .o_remainder(remainder)
`ifdef DIV_DBZ_DETECT_EN
    , .o_dbz(dbz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives start for one edge; returns 1ns after that edge (edge k).
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; signed_op = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done; ok drops if busy falls or done rises early.
  task automatic wait_done(output int n, output bit ok);
    n = 0; ok = 1'b1;
    while (n < 100) begin
      if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
      @(posedge clk); #1; n++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int lat, input logic [31:0] eq, input logic [31:0] er);
    int n; bit ok;
    launch(a, b, s);
    wait_done(n, ok);
    check({tag, " latency"}, n, lat);
    check({tag, " busy-window"}, ok, 1'b1);
    check({tag, " busy-at-done"}, busy, 1'b0);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
  endtask

  initial begin
    int  n;
    bit  ok;
    bit  no_done;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    #12;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset quotient", quotient, 32'h0);
    check("reset remainder", remainder, 32'h0);
`ifdef DIV_DBZ_DETECT_EN
    check("reset dbz", dbz, 1'b0);
`endif
    @(negedge clk); rst = 1'b0;

    run_op("u100/7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2);
    @(posedge clk); #1;
    check("done one-cycle", done, 1'b0);
    check("result held", quotient, 32'd14);

    run_op("s-100/7", 32'hFFFFFF9C, 32'd7, 1'b1, 33, 32'hFFFFFFF2, 32'hFFFFFFFE);
    run_op("s100/-7", 32'd100, 32'hFFFFFFF9, 1'b1, 33, 32'hFFFFFFF2, 32'd2);
    run_op("s-min/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 33, 32'h80000000, 32'h0);
    run_op("uMax/1", 32'hFFFFFFFF, 32'd1, 1'b0, 33, 32'hFFFFFFFF, 32'h0);

    // start pulsed mid-RUN must be dropped
    launch(32'd50, 32'd5, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    start = 1'b1; dividend = 32'd99; divisor = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, ok);
    check("ignored-start latency", 11 + n, 33);
    check("ignored-start busy-window", ok, 1'b1);
    check("ignored-start quotient", quotient, 32'd10);
    check("ignored-start remainder", remainder, 32'd0);
    @(posedge clk); #1;
    check("ignored-start no 2nd done", done, 1'b0);
    check("ignored-start idle", busy, 1'b0);

    // start in the done cycle is accepted
    launch(32'd20, 32'd6, 1'b0);
    wait_done(n, ok);
    check("b2b first quotient", quotient, 32'd3);
    check("b2b first remainder", remainder, 32'd2);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3; signed_op = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b accepted busy", busy, 1'b1);
    check("b2b done dropped", done, 1'b0);
    wait_done(n, ok);
    check("b2b second latency", n, 33);
    check("b2b second quotient", quotient, 32'd3);
    check("b2b second remainder", remainder, 32'd0);

    // reset mid-operation
    launch(32'd1000, 32'd3, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort quotient", quotient, 32'h0);
    check("abort remainder", remainder, 32'h0);
    @(negedge clk); rst = 1'b0;
    no_done = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0; end
    check("abort no done", no_done, 1'b1);
    run_op("u5/2", 32'd5, 32'd2, 1'b0, 33, 32'd2, 32'd1);

`ifdef DIV_DBZ_DETECT_EN
    run_op("u7/0", 32'd7, 32'd0, 1'b0, 1, 32'hFFFFFFFF, 32'd7);
    check("u7/0 dbz", dbz, 1'b1);
    run_op("s-7/0", 32'hFFFFFFF9, 32'd0, 1'b1, 1, 32'hFFFFFFFF, 32'hFFFFFFF9);
    check("s-7/0 dbz", dbz, 1'b1);
    run_op("u9/3", 32'd9, 32'd3, 1'b0, 33, 32'd3, 32'd0);
    check("dbz cleared", dbz, 1'b0);
`else
    run_op("u7/0", 32'd7, 32'd0, 1'b0, 33, 32'hFFFFFFFF, 32'd7);
    run_op("s-7/0", 32'hFFFFFFF9, 32'd0, 1'b1, 33, 32'h00000001, 32'hFFFFFFF9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
